// File: rtl/dmem_responder.sv
// dmem_responder: load/store bus transaction engine with lane steering, extension, misalign and timeout
module dmem_responder #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memrd_i,
  input  logic              memw_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misalign_o,
  output logic              err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;
  localparam int CW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0] f3_q, f3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req, aligned, timeout, is_req;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic [DATA_W-1:0] load_v, steer_v;
  logic [3:0] be_v;
  assign req = memrd_i | memw_i;
  assign aligned = funct3_i[1:0] == 2'b00 || (funct3_i[1:0] == 2'b01 && !addr_i[0])
                   || (funct3_i[1:0] == 2'b10 && addr_i[1:0] == 2'b00);
  assign timeout = TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST;
  assign is_req = state_q == REQ;
  assign byte_v = bus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
  assign load_v = f3_q[1:0] == 2'b00 ? {{24{byte_v[7] & ~f3_q[2]}}, byte_v}
                : f3_q[1:0] == 2'b01 ? {{16{half_v[15] & ~f3_q[2]}}, half_v}
                : bus_rdata_i;
  assign be_v = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
              : f3_q[1:0] == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011)
              : 4'b1111;
  assign steer_v = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
                 : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}}
                 : wdata_q;
  assign stall_o = (state_q == IDLE && req) || is_req || state_q == WAIT_R;
  assign done_o = state_q == DONE;
  assign misalign_o = done_o & mis_q;
  assign err_o = done_o & err_q;
  assign rdata_o = rdata_q;
  assign bus_req_o = is_req;
  assign bus_we_o = is_req & we_q;
  assign bus_addr_o = is_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be_o = is_req ? be_v : 4'b0000;
  assign bus_wdata_o = is_req && we_q ? steer_v : '0;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    f3_d = f3_q;
    wdata_d = wdata_q;
    we_d = we_q;
    mis_d = mis_q;
    err_d = err_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        addr_d = addr_i;
        f3_d = funct3_i;
        wdata_d = wdata_i;
        we_d = memw_i;
        mis_d = ~aligned;
        err_d = 1'b0;
        cnt_d = '0;
        state_d = aligned ? REQ : DONE;
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_gnt_i) state_d = we_q ? DONE : WAIT_R;
        else if (timeout) begin
          state_d = DONE;
          err_d = 1'b1;
          rdata_d = we_q ? rdata_q : '0;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid_i) begin
          rdata_d = load_v;
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
          err_d = 1'b1;
          rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      f3_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      f3_q <= f3_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      mis_q <= mis_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory side of the core's load/store control: responds to memrd/memw strobes from the decode/control path and runs a multi-cycle request/grant/response transaction on the data-memory bus.
- Stalls the pipeline until the access completes.
- Handles RV32I access sizes (funct3), store byte-lane steering, load extraction with sign/zero extension, misalignment detection and bus timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; other values unsupported)
TIMEOUT_CYCLES, 64, max cycles waiting in REQ or WAIT_R before abort; 0 disables timeout

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
memrd_i  input  1  load strobe from control path
memw_i  input  1  store strobe from control path
funct3_i  input  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use [1:0] only)
addr_i  input  ADDR_W  effective address from ALU
wdata_i  input  DATA_W  store data (rs2)
stall_o  output  1  hold pipeline
done_o  output  1  one-cycle completion pulse
rdata_o  output  DATA_W  extended load result
misalign_o  output  1  one-cycle pulse: misaligned access, no bus activity
err_o  output  1  one-cycle pulse: bus timeout
bus_req_o  output  1  bus request
bus_we_o  output  1  1 = write
bus_addr_o  output  ADDR_W  word-aligned address (addr[1:0] forced 00)
bus_be_o  output  4  byte enables
bus_wdata_o  output  DATA_W  lane-steered write data
bus_gnt_i  input  1  request accepted
bus_rvalid_i  input  1  read data valid
bus_rdata_i  input  DATA_W  read data

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0 incl. rdata_o, bus_* outputs; timeout counter 0. Reset mid-transaction abandons it; bus_req_o drops at once. No done/err pulse.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE: request = memrd_i | memw_i. Both high → treated as store. On request: capture addr, funct3, wdata, we into registers, evaluate alignment.
  - Aligned: size 00 always; size 01 needs addr[0]=0; size 10 needs addr[1:0]=00; size 11 is misaligned.
  - Aligned → REQ. Misaligned → DONE with misalign flag; no bus_req ever asserted.
- stall_o = (IDLE & request) | REQ | WAIT_R. Combinational, so the pipeline holds in the request cycle. stall_o=0 in DONE.
- REQ: bus_req_o=1 and bus_we_o/addr/be/wdata held stable from the registers until bus_gnt_i samples 1.
  - Store + gnt → DONE.
  - Load + gnt → WAIT_R.
  - rvalid in the same cycle as gnt is ignored; rvalid is earliest one cycle after gnt.
- WAIT_R: bus_req_o=0. On bus_rvalid_i: extract lane and extend, register into rdata_o → DONE.
  - Byte: lane addr[1:0]. Half: lane addr[1].
  - funct3[2]=0 sign-extend, =1 zero-extend. Word: as-is.
- Store steering:
  - Byte: wdata[7:0] replicated x4, be = 0001<<addr[1:0].
  - Half: wdata[15:0] replicated x2, be = 0011<<(2*addr[1]).
  - Word: be=1111.
  - Loads drive be per same rule; bus_wdata_o don't-care but driven 0.
- Timeout: counter clears on entry to REQ, increments each cycle in REQ/WAIT_R.
  - Reaching TIMEOUT_CYCLES → DONE with err flag. bus_req_o drops. rdata_o=0 if the access was a load.
  - Late rvalid after abort is ignored in IDLE.
- DONE: exactly one cycle. done_o=1; misalign_o/err_o=1 if flagged; stall_o=0; → IDLE.
  - Requests present during DONE are not accepted. They are accepted the next cycle in IDLE.
- rdata_o holds its value until the next load completes or aborts. Stores never modify it.
- Latency: aligned store = 1 (IDLE) + grant wait + 1 (DONE). Load adds response wait. Minimum store 3 cycles, minimum load 4 cycles from strobe to done.

Test Plan:
- lw addr 0x1000_0008, gnt after 2 REQ cycles, rvalid 1 cycle later with 0xDEADBEEF → bus_addr 0x1000_0008, be 1111, done_o pulse, rdata_o=0xDEADBEEF, stall_o high for all cycles before DONE.
- lb addr 0x...03, rdata 0x80FF_FF00 → rdata_o=0xFFFF_FF80. lbu same → 0x0000_0080. lhu addr 0x...02, rdata 0xBEEF_0000 → 0x0000_BEEF.
- sh addr 0x...02, wdata 0x1234_ABCD, immediate gnt → bus_we_o=1, be=1100, bus_wdata=0xABCD_ABCD, done 2 cycles after strobe. sb addr 0x...01, wdata 0x55 → be=0010, wdata 0x5555_5555.
- lw addr 0x...01 and sh addr 0x...03 → misalign_o and done_o pulse on the next cycle, bus_req_o never 1, rdata_o unchanged.
- TIMEOUT_CYCLES=4, gnt never asserted → err_o+done_o after 4 REQ cycles, bus_req_o low afterwards. Repeat with gnt but no rvalid → err_o, rdata_o=0.
- Assert rst during WAIT_R → all outputs 0 immediately. A later rvalid is ignored. A following lw completes normally.
